// File: rtl/fb_pkg.sv
// Shared types, limits and helpers for the framebuffer rectangle fill engine.
package fb_pkg;

    localparam int FB_XMAX = 127;
    localparam int FB_YMAX = 63;
    localparam int FB_CW   = 8;
    localparam int FB_DW   = 8;

    typedef logic [FB_CW-1:0] coord_t;
    typedef logic [FB_DW-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_FB = 3'd1,
        WRITE   = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Saturate a coordinate to the last valid index of its axis.
    function automatic coord_t clamp(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

    // Checkerboard cells (odd x^y) receive the inverted pattern.
    function automatic data_t cell_data(input data_t pat, input logic chk,
                                        input coord_t x, input coord_t y);
        return (chk && (x[0] ^ y[0])) ? ~pat : pat;
    endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster position counter: normalises/clamps the corners on load and walks
// x inner, y outer on each step. Flags the final cell of the rectangle.
module fb_raster_counter
    import fb_pkg::*;
#(
    parameter int XMAX = FB_XMAX,
    parameter int YMAX = FB_YMAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [FB_CW-1:0] x0_i,
    input  logic [FB_CW-1:0] y0_i,
    input  logic [FB_CW-1:0] x1_i,
    input  logic [FB_CW-1:0] y1_i,
    output logic [FB_CW-1:0] x_o,
    output logic [FB_CW-1:0] y_o,
    output logic             last_o
);

    localparam coord_t XLIM = coord_t'(XMAX);
    localparam coord_t YLIM = coord_t'(YMAX);

    coord_t xs_q, xe_q, ys_q, ye_q, x_q, y_q;
    coord_t xs_d, xe_d, ys_d, ye_d, x_d, y_d;

    // Next position: load sorted/clamped bounds, or advance in raster order.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        xs_d = xs_q;
        xe_d = xe_q;
        ys_d = ys_q;
        ye_d = ye_q;
        x_d  = x_q;
        y_d  = y_q;
        if (load_i) begin
            xs_d = clamp((x0_i < x1_i) ? x0_i : x1_i, XLIM);
            xe_d = clamp((x0_i < x1_i) ? x1_i : x0_i, XLIM);
            ys_d = clamp((y0_i < y1_i) ? y0_i : y1_i, YLIM);
            ye_d = clamp((y0_i < y1_i) ? y1_i : y0_i, YLIM);
            x_d  = xs_d;
            y_d  = ys_d;
        end else if (step_i) begin
            // Equality compares only, so the increment can never wrap past xe/ye.
            if (x_q == xe_q) begin
                x_d = xs_q;
                if (y_q != ye_q) y_d = y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    // Position and bound registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            xs_q <= '0;
            xe_q <= '0;
            ys_q <= '0;
            ye_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            xs_q <= xs_d;
            xe_q <= xe_d;
            ys_q <= ys_d;
            ye_q <= ye_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts one command and issues one framebuffer
// write per cell in raster order, with an ack timeout that aborts the fill.
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int XMAX           = FB_XMAX,
    parameter int YMAX           = FB_YMAX,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [FB_CW-1:0] cmd_x0,
    input  logic [FB_CW-1:0] cmd_y0,
    input  logic [FB_CW-1:0] cmd_x1,
    input  logic [FB_CW-1:0] cmd_y1,
    input  logic [FB_DW-1:0] cmd_pattern,
    input  logic             cmd_checker,
    input  logic             fb_busy,
    output logic             fb_we,
    output logic [FB_CW-1:0] fb_w_xpos,
    output logic [FB_CW-1:0] fb_w_ypos,
    output logic [FB_DW-1:0] fb_din,
    input  logic             fb_w_data_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [WW-1:0]  wait_q;
    data_t          pattern_q, din_q;
    logic           checker_q, err_q;
    coord_t         xpos_q, ypos_q;
    coord_t         cur_x, cur_y;
    logic           last_cell, timeout;
    logic           ctr_load, ctr_step, issue;

    fb_raster_counter #(.XMAX(XMAX), .YMAX(YMAX)) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ctr_load),
        .step_i (ctr_step),
        .x0_i   (cmd_x0),
        .y0_i   (cmd_y0),
        .x1_i   (cmd_x1),
        .y1_i   (cmd_y1),
        .x_o    (cur_x),
        .y_o    (cur_y),
        .last_o (last_cell)
    );

    assign timeout = (wait_q == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an ack on the timeout cycle still counts as success.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = WAIT_FB;
            WAIT_FB: if (!fb_busy)  state_d = WRITE;
            WRITE: begin
                if (fb_w_data_valid) state_d = ADVANCE;
                else if (timeout)    state_d = DONE;
            end
            ADVANCE: state_d = last_cell ? DONE : WAIT_FB;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs and datapath controls.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q == WAIT_FB) || (state_q == WRITE) || (state_q == ADVANCE);
        done      = (state_q == DONE);
        fb_we     = (state_q == WRITE);
        ctr_load  = (state_q == IDLE) && cmd_valid;
        ctr_step  = (state_q == ADVANCE);
        issue     = (state_q == WAIT_FB) && !fb_busy;
    end

    // Command payload, write address/data capture, ack wait counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            checker_q <= 1'b0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            din_q     <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (ctr_load) begin
                pattern_q <= cmd_pattern;
                checker_q <= cmd_checker;
                err_q     <= 1'b0;
            end
            if (issue) begin
                xpos_q <= cur_x;
                ypos_q <= cur_y;
                din_q  <= cell_data(pattern_q, checker_q, cur_x, cur_y);
            end
            // Counter runs only while a write is outstanding; zero on WRITE entry.
            if (state_q == WRITE) wait_q <= wait_q + WW'(1);
            else                  wait_q <= '0;
            if ((state_q == WRITE) && !fb_w_data_valid && timeout) err_q <= 1'b1;
        end
    end

    assign fb_w_xpos = xpos_q;
    assign fb_w_ypos = ypos_q;
    assign fb_din    = din_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: table-driven rectangles, randomized
// rectangles against a raster reference model, plus busy/timeout/reset sequences.
module tb_fb_rect_fill;

    localparam int XMAX = 127;
    localparam int YMAX = 63;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0, cmd_pattern = '0;
    logic       cmd_checker = 1'b0;
    logic       fb_busy = 1'b0;
    logic       fb_we;
    logic [7:0] fb_w_xpos, fb_w_ypos, fb_din;
    logic       fb_w_data_valid = 1'b0;
    logic       busy, done, err;

    fb_rect_fill #(.XMAX(XMAX), .YMAX(YMAX), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_x0          (cmd_x0),
        .cmd_y0          (cmd_y0),
        .cmd_x1          (cmd_x1),
        .cmd_y1          (cmd_y1),
        .cmd_pattern     (cmd_pattern),
        .cmd_checker     (cmd_checker),
        .fb_busy         (fb_busy),
        .fb_we           (fb_we),
        .fb_w_xpos       (fb_w_xpos),
        .fb_w_ypos       (fb_w_ypos),
        .fb_din          (fb_din),
        .fb_w_data_valid (fb_w_data_valid),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- framebuffer model / monitor (negedge) ----------------
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    logic [23:0] wq[$];
    logic [23:0] hold = '0;
    logic        prev_we = 1'b0;
    int          we_run = 0;
    int          last_we_len = 0;
    int          unstable = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
            we_run = 0;
            fb_w_data_valid = 1'b0;
        end else begin
            if (fb_we) begin
                if (!prev_we) begin
                    hold = {fb_w_xpos, fb_w_ypos, fb_din};
                    wq.push_back(hold);
                    we_run = 0;
                end else if ({fb_w_xpos, fb_w_ypos, fb_din} != hold) begin
                    unstable++;
                end
                we_run++;
            end else if (prev_we) begin
                last_we_len = we_run;
            end
            prev_we = fb_we;
            if (done) done_cnt++;
            fb_w_data_valid = ack_en && fb_we && (we_run > ack_delay);
        end
    end

    // ---------------- reference model: rectangle -> ordered cell list ----------------
    logic [23:0] exp_q[$];

    task automatic build_exp(input int x0, input int y0, input int x1, input int y1,
                             input logic [7:0] pat, input logic chk);
        int xs, xe, ys, ye;
        logic [7:0] d;
        xs = (x0 < x1) ? x0 : x1;  xe = (x0 < x1) ? x1 : x0;
        ys = (y0 < y1) ? y0 : y1;  ye = (y0 < y1) ? y1 : y0;
        if (xs > XMAX) xs = XMAX;
        if (xe > XMAX) xe = XMAX;
        if (ys > YMAX) ys = YMAX;
        if (ye > YMAX) ye = YMAX;
        exp_q.delete();
        for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++) begin
                d = (chk && (((x + y) % 2) == 1)) ? ~pat : pat;
                exp_q.push_back({8'(x), 8'(y), d});
            end
    endtask

    int base_w, base_done;

    task automatic snapshot();
        base_w = wq.size();
        base_done = done_cnt;
    endtask

    task automatic start_cmd(input logic [7:0] x0, input logic [7:0] y0,
                             input logic [7:0] x1, input logic [7:0] y1,
                             input logic [7:0] pat, input logic chk, input bit hold_valid);
        @(negedge clk);
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
        cmd_pattern = pat; cmd_checker = chk; cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold_valid) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget && done_cnt == base_done; i++) @(negedge clk);
        check({name, " done seen in budget"}, 32'(done_cnt != base_done), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic verify_seq(input string name);
        int n, mism;
        n = wq.size() - base_w;
        mism = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (wq[base_w + i] != exp_q[i]) mism++;
        check({name, " write count"}, 32'(n), 32'(exp_q.size()));
        check({name, " cell/data mismatches"}, 32'(mism), 32'd0);
        check({name, " done pulses"}, 32'(done_cnt - base_done), 32'd1);
        check({name, " busy after done"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] x0, y0, x1, y1, pat;
        logic       chk;
        int         dly;
        int         exp_n;
        logic [23:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'd2,   8'd1,  8'd4,   8'd2,   8'hFF, 1'b0, 2, 6,    {8'd4,   8'd2,  8'hFF}};
        vecs[1] = '{8'd200, 8'd70, 8'd126, 8'd62,  8'hA5, 1'b0, 1, 4,    {8'd127, 8'd63, 8'hA5}};
        vecs[2] = '{8'd0,   8'd0,  8'd1,   8'd1,   8'h0F, 1'b1, 0, 4,    {8'd1,   8'd1,  8'h0F}};
        vecs[3] = '{8'd5,   8'd5,  8'd5,   8'd5,   8'h3C, 1'b1, 3, 1,    {8'd5,   8'd5,  8'h3C}};
        vecs[4] = '{8'd130, 8'd10, 8'd140, 8'd10,  8'h77, 1'b1, 0, 1,    {8'd127, 8'd10, 8'h88}};
        vecs[5] = '{8'd0,   8'd0,  8'd255, 8'd255, 8'h00, 1'b0, 0, 8192, {8'd127, 8'd63, 8'h00}};

        // ---- reset state ----
        #2;
        check("reset fb_we", 32'(fb_we), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset addr/data", 32'({fb_w_xpos, fb_w_ypos, fb_din}), 32'd0);
        #21 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- table-driven rectangles ----
        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            ack_delay = vecs[v].dly;
            build_exp(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].pat, vecs[v].chk);
            snapshot();
            start_cmd(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].pat, vecs[v].chk, 1'b0);
            check({nm, " busy after accept"}, 32'(busy), 32'd1);
            wait_done(nm, vecs[v].exp_n * (vecs[v].dly + 4) + 100);
            verify_seq(nm);
            check({nm, " hand count"}, 32'(wq.size() - base_w), 32'(vecs[v].exp_n));
            check({nm, " last cell"}, 32'((wq.size() > base_w) ? wq[wq.size()-1] : 24'hFFFFFF),
                  32'(vecs[v].exp_last));
            check({nm, " err"}, 32'(err), 32'd0);
        end

        // ---- fb_busy held high for 50 cycles after accept ----
        begin
            int highs;
            fb_busy = 1'b1;
            ack_delay = 0;
            build_exp(10, 20, 10, 20, 8'h5A, 1'b0);
            snapshot();
            start_cmd(8'd10, 8'd20, 8'd10, 8'd20, 8'h5A, 1'b0, 1'b0);
            highs = 0;
            repeat (50) begin
                @(negedge clk);
                if (fb_we) highs++;
            end
            check("fbbusy no write while busy", 32'(highs), 32'd0);
            @(posedge clk); #1 fb_busy = 1'b0;
            @(negedge clk);
            check("fbbusy we before sample", 32'(fb_we), 32'd0);
            @(negedge clk);
            check("fbbusy we cycle after sample", 32'(fb_we), 32'd1);
            wait_done("fbbusy", 200);
            verify_seq("fbbusy");
        end

        // ---- ack never returned: timeout abort, then err cleared by next command ----
        ack_en = 1'b0;
        build_exp(3, 3, 4, 3, 8'h11, 1'b0);
        snapshot();
        start_cmd(8'd3, 8'd3, 8'd4, 8'd3, 8'h11, 1'b0, 1'b0);
        wait_done("tmo", 200);
        check("tmo we high cycles", 32'(last_we_len), 32'(TMO));
        check("tmo writes issued", 32'(wq.size() - base_w), 32'd1);
        check("tmo done pulses", 32'(done_cnt - base_done), 32'd1);
        check("tmo err set", 32'(err), 32'd1);
        check("tmo we low after", 32'(fb_we), 32'd0);
        ack_en = 1'b1;
        ack_delay = 1;
        build_exp(1, 1, 2, 1, 8'h22, 1'b0);
        snapshot();
        start_cmd(8'd1, 8'd1, 8'd2, 8'd1, 8'h22, 1'b0, 1'b0);
        check("tmo err cleared on accept", 32'(err), 32'd0);
        wait_done("post-tmo", 200);
        verify_seq("post-tmo");

        // ---- reset mid-fill with cmd_valid held ----
        begin
            int i;
            ack_delay = 1;
            snapshot();
            start_cmd(8'd0, 8'd0, 8'd3, 8'd3, 8'hC3, 1'b1, 1'b1);
            for (i = 0; i < 200 && (wq.size() - base_w) < 3; i++) @(negedge clk);
            while (!fb_we && i < 400) begin @(negedge clk); i++; end
            #1 rst_n = 1'b0;
            #1;
            check("rst fb_we async drop", 32'(fb_we), 32'd0);
            check("rst busy", 32'(busy), 32'd0);
            check("rst err", 32'(err), 32'd0);
            check("rst addr/data", 32'({fb_w_xpos, fb_w_ypos, fb_din}), 32'd0);
            repeat (3) @(negedge clk);
            check("rst no done pulse", 32'(done_cnt - base_done), 32'd0);
            build_exp(0, 0, 3, 3, 8'hC3, 1'b1);
            snapshot();
            #2 rst_n = 1'b1;
            for (i = 0; i < 20 && !busy; i++) @(negedge clk);
            check("rst held cmd accepted", 32'(busy), 32'd1);
            cmd_valid = 1'b0;
            wait_done("rst-restart", 200);
            verify_seq("rst-restart");
            check("rst restart first cell", 32'((wq.size() > base_w) ? wq[base_w] : 24'hFFFFFF),
                  32'(exp_q[0]));
        end

        // ---- randomized rectangles vs reference model ----
        for (int r = 0; r < 25; r++) begin
            int x0, y0, x1, y1;
            logic [7:0] pat;
            logic chk;
            x0 = $urandom_range(0, 140);
            y0 = $urandom_range(0, 75);
            x1 = x0 + $urandom_range(0, 8) - 4;
            y1 = y0 + $urandom_range(0, 6) - 3;
            if (x1 < 0) x1 = 0;
            if (y1 < 0) y1 = 0;
            pat = 8'($urandom);
            chk = 1'($urandom_range(0, 1));
            ack_delay = $urandom_range(0, 3);
            build_exp(x0, y0, x1, y1, pat, chk);
            snapshot();
            start_cmd(8'(x0), 8'(y0), 8'(x1), 8'(y1), pat, chk, 1'b0);
            wait_done($sformatf("rand%0d", r), exp_q.size() * 8 + 100);
            verify_seq($sformatf("rand%0d", r));
            check($sformatf("rand%0d err", r), 32'(err), 32'd0);
        end

        check("address/data stable during fb_we", 32'(unstable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
- Command-driven fill engine that sits directly upstream of the framebuffer write port (we / w_xpos / w_ypos / din / w_data_valid / busy).
- Accepts one rectangle command at a time and issues one framebuffer write per (x,y) cell in raster order.
- Replaces the ad-hoc pattern writer in the top level.
- Also used for screen clears: full-screen rectangle with pattern 8'h00.

Parameters:
- XMAX, 127, last valid x coordinate; coordinates above it are clamped.
- YMAX, 63, last valid y coordinate; coordinates above it are clamped.
- TIMEOUT_CYCLES, 1024, cycles to wait for fb_w_data_valid before aborting the command.

Ports:
- clk  in  1  system clock (27 MHz)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_x0  in  8  corner A x
- cmd_y0  in  8  corner A y
- cmd_x1  in  8  corner B x
- cmd_y1  in  8  corner B y
- cmd_pattern  in  8  data byte written to each cell
- cmd_checker  in  1  when 1, cells with (x^y)[0]=1 receive ~cmd_pattern
- fb_busy  in  1  framebuffer busy
- fb_we  out  1  framebuffer write enable
- fb_w_xpos  out  8  write x
- fb_w_ypos  out  8  write y
- fb_din  out  8  write data
- fb_w_data_valid  in  1  framebuffer write acknowledge
- busy  out  1  high from command accept until return to IDLE
- done  out  1  one-cycle pulse when a command completes or aborts
- err  out  1  sticky; set on timeout, cleared on next accepted command

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - fb_we, fb_w_xpos, fb_w_ypos, fb_din, busy, done, err all 0.
  - cmd_ready=1.
- Command accept, in IDLE on cmd_valid:
  - Latch the command.
  - Normalise: xs=min(x0,x1), xe=max(x0,x1); same for y.
  - Clamp xs/xe to XMAX and ys/ye to YMAX.
  - x=xs, y=ys; clear err; busy=1; go to WAIT_FB.
- WAIT_FB:
  - When fb_busy=0: drive fb_w_xpos=x, fb_w_ypos=y, fb_din=pattern (inverted per checker rule), fb_we=1; go to WRITE.
  - Write fires the cycle after fb_busy is sampled low.
- WRITE:
  - Hold fb_we and address/data stable.
  - On fb_w_data_valid: fb_we=0 and go to ADVANCE.
  - A wait counter is cleared on WRITE entry and increments each cycle. When it reaches TIMEOUT_CYCLES-1 without an ack: fb_we=0, err=1, go to DONE (abort; remaining cells are skipped).
- ADVANCE:
  - fb_we stays 0, so there is at least one idle cycle between writes.
  - If x==xe: x=xs, then if y==ye go to DONE, else y=y+1.
  - Otherwise x=x+1.
  - Go to WAIT_FB.
  - Comparisons use the 8-bit equality path, so there is no overflow at XMAX=255.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- Ordering: raster, x inner and y outer. Cell count = (xe-xs+1)*(ye-ys+1).
- Minimum cost per cell: 3 cycles (WAIT_FB, WRITE with same-cycle ack seen next edge, ADVANCE) when fb_busy=0 and the ack is immediate.
- Degenerate rectangle (xs==xe, ys==ye): exactly one write.
- cmd_valid while busy: ignored (cmd_ready=0); the requester must hold it.
- An fb_w_data_valid arriving outside WRITE is ignored.
- fb_busy rising during WRITE has no effect; the engine waits only for the ack.
- rst_n asserted mid-command: immediate return to reset values; fb_we drops asynchronously; no done pulse.

Decomposition:
- Shared package fb_pkg:
  - FB_XMAX=127, FB_YMAX=63.
  - Coordinate width 8, data width 8.
  - State encoding constants IDLE/WAIT_FB/WRITE/ADVANCE/DONE.
- Sub-module fb_raster_counter: holds x/y and the bounds; inputs load/step; outputs x, y, last. Keeps the FSM free of arithmetic.

Test Plan:
- Rect (2,1)-(4,2), pattern 8'hFF, checker=0, framebuffer model acks after 2 cycles -> 6 writes in order (2,1),(3,1),(4,1),(2,2),(3,2),(4,2), all din=FF, fb_we low ≥1 cycle between them, single done pulse, err=0.
- Swapped/clamped corners (200,70)-(126,62), pattern 8'hA5 -> bounds x 126..127, y 62..63; exactly 4 writes; last write at (127,63).
- Checker: (0,0)-(1,1), pattern 8'h0F, checker=1 -> din sequence 0F, F0, F0, 0F.
- fb_busy held high for 50 cycles after accept -> fb_we stays 0 throughout; first write begins the cycle after fb_busy falls.
- Ack never returned, TIMEOUT_CYCLES=16 -> fb_we high for exactly 16 cycles then drops; err=1; done pulses; next accepted command clears err.
- rst_n pulsed low mid-fill with cmd_valid held -> outputs zero immediately, no done pulse; after release the held command is accepted and the fill restarts at (xs,ys).
